// File: rtl/irq_ctrl_plic_lite.sv
// Lightweight platform interrupt controller: level (optionally edge) gateways, priority
// arbitration and claim/complete over an MMIO window. Optional edge mode: IRQ_CTRL_EDGE_TRIG_EN.
module irq_ctrl_plic_lite #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               bus_req_i,
  input  logic               bus_we_i,
  input  logic [7:0]         bus_addr_i,
  input  logic [31:0]        bus_wdata_i,
  output logic [31:0]        bus_rdata_o,
  output logic               bus_ready_o,
  output logic               irq_o,
  output logic [4:0]         irq_id_o
);

  localparam logic [5:0] AddrPending = 6'h00;
  localparam logic [5:0] AddrEnable  = 6'h01;
  localparam logic [5:0] AddrThresh  = 6'h02;
  localparam logic [5:0] AddrClaim   = 6'h03;
`ifdef IRQ_CTRL_EDGE_TRIG_EN
  localparam logic [5:0] AddrEdge    = 6'h04;
`endif

  logic [NUM_SRC-1:0] sync1_q, sync2_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] in_service_q, in_service_d;
  logic [NUM_SRC-1:0] enable_q;
  logic [NUM_SRC-1:0] gw_set, claim_mask, complete_mask;
  logic [PRIO_W-1:0]  thresh_q;
  logic [PRIO_W-1:0]  prio_q [NUM_SRC];
  logic [4:0]         best_id;
  logic [PRIO_W-1:0]  best_prio;
  logic [31:0]        rdata_d, rdata_q;
  logic               ready_q, irq_q;
  logic [4:0]         irq_id_q;
  logic [5:0]         word;
  logic               wr, rd, claim, complete;
  logic               unused_bits;

  assign word        = bus_addr_i[7:2];
  assign wr          = bus_req_i & bus_we_i;
  assign rd          = bus_req_i & ~bus_we_i;
  assign claim       = rd & (word == AddrClaim);
  assign complete    = wr & (word == AddrClaim);
  assign unused_bits = ^{bus_addr_i[1:0], bus_wdata_i};

`ifdef IRQ_CTRL_EDGE_TRIG_EN
  logic [NUM_SRC-1:0] edge_q, sync3_q;
  // Edge sources ignore in_service, so a completed held-high line never re-pends.
  assign gw_set = ~pending_q & ((~edge_q & sync2_q & ~in_service_q) |
                                (edge_q & sync2_q & ~sync3_q));
`else
  assign gw_set = ~pending_q & sync2_q & ~in_service_q;
`endif

  // Strict '>' while scanning upward keeps the lowest ID on equal priority.
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (pending_q[k] && enable_q[k] && (prio_q[k] > thresh_q) && (prio_q[k] > best_prio)) begin
        best_id   = 5'(k + 1);
        best_prio = prio_q[k];
      end
    end
  end

  always_comb begin
    claim_mask    = '0;
    complete_mask = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      claim_mask[k]    = claim && (best_id == 5'(k + 1));
      complete_mask[k] = complete && (bus_wdata_i[4:0] == 5'(k + 1)) && in_service_q[k];
    end
  end

  // Claim clears after the gateway OR, so a same-cycle set of the claimed ID loses.
  assign pending_d    = (pending_q | gw_set) & ~claim_mask;
  assign in_service_d = (in_service_q | claim_mask) & ~complete_mask;

  always_comb begin
    rdata_d = '0;
    case (word)
      AddrPending: rdata_d = 32'(pending_q);
      AddrEnable:  rdata_d = 32'(enable_q);
      AddrThresh:  rdata_d = 32'(thresh_q);
      AddrClaim:   rdata_d = 32'(best_id);
`ifdef IRQ_CTRL_EDGE_TRIG_EN
      AddrEdge:    rdata_d = 32'(edge_q);
`endif
      default: begin
        for (int k = 0; k < NUM_SRC; k++) begin
          if (word == 6'(8 + k)) rdata_d = 32'(prio_q[k]);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      enable_q     <= '0;
      thresh_q     <= '0;
      for (int k = 0; k < NUM_SRC; k++) prio_q[k] <= '0;
`ifdef IRQ_CTRL_EDGE_TRIG_EN
      edge_q       <= '0;
      sync3_q      <= '0;
`endif
      rdata_q      <= '0;
      ready_q      <= 1'b0;
      irq_q        <= 1'b0;
      irq_id_q     <= '0;
    end else begin
      sync1_q      <= src_i;
      sync2_q      <= sync1_q;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
`ifdef IRQ_CTRL_EDGE_TRIG_EN
      sync3_q      <= sync2_q;
      if (wr && (word == AddrEdge)) edge_q <= bus_wdata_i[NUM_SRC-1:0];
`endif
      if (wr && (word == AddrEnable)) enable_q <= bus_wdata_i[NUM_SRC-1:0];
      if (wr && (word == AddrThresh)) thresh_q <= bus_wdata_i[PRIO_W-1:0];
      for (int k = 0; k < NUM_SRC; k++) begin
        if (wr && (word == 6'(8 + k))) prio_q[k] <= bus_wdata_i[PRIO_W-1:0];
      end
      rdata_q      <= rd ? rdata_d : '0;
      ready_q      <= bus_req_i;
      irq_q        <= (best_id != 5'd0);
      irq_id_q     <= best_id;
    end
  end

  assign bus_rdata_o = rdata_q;
  assign bus_ready_o = ready_q;
  assign irq_o       = irq_q;
  assign irq_id_o    = irq_id_q;

endmodule

// File: tb/tb_irq_ctrl_plic_lite.sv
// Directed self-checking bench for irq_ctrl_plic_lite: latency, claim/complete,
// arbitration, threshold/enable, ignored completes, unmapped access and reset mid-access.
module tb_irq_ctrl_plic_lite;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  src_i = '0;
  logic        bus_req_i = 1'b0;
  logic        bus_we_i = 1'b0;
  logic [7:0]  bus_addr_i = '0;
  logic [31:0] bus_wdata_i = '0;
  logic [31:0] bus_rdata_o;
  logic        bus_ready_o;
  logic        irq_o;
  logic [4:0]  irq_id_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rd;

  irq_ctrl_plic_lite #(.NUM_SRC(8), .PRIO_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_i       (src_i),
    .bus_req_i   (bus_req_i),
    .bus_we_i    (bus_we_i),
    .bus_addr_i  (bus_addr_i),
    .bus_wdata_i (bus_wdata_i),
    .bus_rdata_o (bus_rdata_o),
    .bus_ready_o (bus_ready_o),
    .irq_o       (irq_o),
    .irq_id_o    (irq_id_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Request driven after a falling edge, result sampled on the following falling edge.
  task automatic bus_acc(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                         output logic [31:0] rdata);
    @(negedge clk);
    bus_req_i   = 1'b1;
    bus_we_i    = we;
    bus_addr_i  = addr;
    bus_wdata_i = wd;
    @(negedge clk);
    check_eq("ready", 32'(bus_ready_o), 32'd1);
    rdata     = bus_rdata_o;
    bus_req_i = 1'b0;
    bus_we_i  = 1'b0;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] wd);
    logic [31:0] dummy;
    bus_acc(1'b1, addr, wd, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    bus_acc(1'b0, addr, 32'd0, v);
    check_eq(tag, v, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    cycles(2);
    check_eq("rst_irq", 32'(irq_o), 32'd0);
    check_eq("rst_id", 32'(irq_id_o), 32'd0);
    check_eq("rst_ready", 32'(bus_ready_o), 32'd0);
    check_eq("rst_rdata", bus_rdata_o, 32'd0);
    rst_n = 1'b1;
    cycles(1);

    // Level interrupt and its latency
    wr(8'h28, 32'd2);
    wr(8'h04, 32'h04);
    wr(8'h08, 32'd0);
    rd_chk("prio3_rd", 8'h28, 32'd2);
    rd_chk("enable_rd", 8'h04, 32'h04);
    src_i[2] = 1'b1;
    cycles(3);
    check_eq("lat_edge3_irq", 32'(irq_o), 32'd0);
    cycles(1);
    check_eq("lat_edge4_irq", 32'(irq_o), 32'd1);
    check_eq("lat_edge4_id", 32'(irq_id_o), 32'd3);

    // Claim, then complete with source still high
    rd_chk("claim3", 8'h0C, 32'd3);
    rd_chk("pend_after_claim", 8'h00, 32'h00);
    check_eq("irq_after_claim", 32'(irq_o), 32'd0);
    wr(8'h0C, 32'd3);
    cycles(2);
    check_eq("irq_repend", 32'(irq_o), 32'd1);
    rd_chk("pend_repend", 8'h00, 32'h04);
    rd_chk("claim3_again", 8'h0C, 32'd3);
    src_i[2] = 1'b0;
    cycles(4);
    wr(8'h0C, 32'd3);
    cycles(3);
    rd_chk("pend_clean", 8'h00, 32'h00);

    // Arbitration: src2 p5, src6 p5, src4 p7
    wr(8'h24, 32'd5);
    wr(8'h34, 32'd5);
    wr(8'h2C, 32'd7);
    wr(8'h04, 32'hFF);
    src_i = 8'b0010_1010;
    cycles(5);
    check_eq("arb_id", 32'(irq_id_o), 32'd4);
    rd_chk("arb_claim1", 8'h0C, 32'd4);
    rd_chk("arb_claim2", 8'h0C, 32'd2);
    rd_chk("arb_claim3", 8'h0C, 32'd6);
    rd_chk("arb_claim4", 8'h0C, 32'd0);
    check_eq("arb_irq_none", 32'(irq_o), 32'd0);

    // Threshold and enable
    src_i = 8'b0000_0010;
    cycles(4);
    wr(8'h0C, 32'd4);
    wr(8'h0C, 32'd6);
    wr(8'h08, 32'd5);
    wr(8'h0C, 32'd2);
    cycles(4);
    rd_chk("thr_pend", 8'h00, 32'h02);
    check_eq("thr5_irq", 32'(irq_o), 32'd0);
    wr(8'h08, 32'd4);
    cycles(2);
    check_eq("thr4_irq", 32'(irq_o), 32'd1);
    check_eq("thr4_id", 32'(irq_id_o), 32'd2);
    wr(8'h04, 32'hFD);
    cycles(2);
    check_eq("dis_irq", 32'(irq_o), 32'd0);
    rd_chk("dis_pend_kept", 8'h00, 32'h02);

    // Ignored completes (id 0, 9, 10) leave src2 in service
    wr(8'h04, 32'hFF);
    cycles(2);
    rd_chk("claim2", 8'h0C, 32'd2);
    wr(8'h0C, 32'd0);
    wr(8'h0C, 32'd9);
    wr(8'h0C, 32'd10);
    cycles(3);
    rd_chk("bad_cpl_pend", 8'h00, 32'h00);
    check_eq("bad_cpl_irq", 32'(irq_o), 32'd0);
    wr(8'h0C, 32'd2);
    cycles(3);
    rd_chk("good_cpl_pend", 8'h00, 32'h02);

    // Unmapped and boundary addresses
    rd_chk("prio8_rd", 8'h3C, 32'd0);
    wr(8'h3C, 32'd6);
    rd_chk("prio8_rd2", 8'h3C, 32'd6);
    wr(8'h40, 32'd7);
    rd_chk("unmapped_40", 8'h40, 32'd0);
    wr(8'h00, 32'hFF);
    rd_chk("pend_ro", 8'h00, 32'h02);
`ifndef IRQ_CTRL_EDGE_TRIG_EN
    wr(8'h10, 32'hFF);
    rd_chk("edge_absent", 8'h10, 32'd0);
`endif

    // Reset pulsed during a claim access
    @(negedge clk);
    bus_req_i  = 1'b1;
    bus_we_i   = 1'b0;
    bus_addr_i = 8'h0C;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_mid_ready", 32'(bus_ready_o), 32'd0);
    check_eq("rst_mid_irq", 32'(irq_o), 32'd0);
    check_eq("rst_mid_id", 32'(irq_id_o), 32'd0);
    check_eq("rst_mid_rdata", bus_rdata_o, 32'd0);
    bus_req_i = 1'b0;
    src_i     = '0;
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("post_rst_pend", 8'h00, 32'h00);
    rd_chk("post_rst_enable", 8'h04, 32'h00);
    rd_chk("post_rst_prio2", 8'h24, 32'h00);

`ifdef IRQ_CTRL_EDGE_TRIG_EN
    wr(8'h10, 32'h01);
    wr(8'h20, 32'd1);
    wr(8'h04, 32'h01);
    rd_chk("edge_rd", 8'h10, 32'h01);
    src_i[0] = 1'b1;
    cycles(3);
    src_i[0] = 1'b0;
    cycles(5);
    rd_chk("edge_pend", 8'h00, 32'h01);
    rd_chk("edge_claim", 8'h0C, 32'd1);
    rd_chk("edge_once", 8'h00, 32'h00);
    src_i[0] = 1'b1;
    cycles(5);
    rd_chk("edge_hold_claim", 8'h0C, 32'd1);
    wr(8'h0C, 32'd1);
    cycles(5);
    rd_chk("edge_no_repend", 8'h00, 32'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
